// File: rtl/bpsk_rx_frame_ctrl.sv
// BPSK receive frame controller: sync hunt in both polarities, length byte,
// payload delivery over valid/ready, and zero-length/overflow/stall aborts.
module bpsk_rx_frame_ctrl #(
    parameter logic [15:0] SYNC_WORD      = 16'hD391,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       byte_last,
    output logic       polarity,
    output logic       busy,
    output logic       frame_start,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        LEN,
        PAYLOAD,
        DRAIN
    } state_t;

    state_t state, state_n;

    logic [15:0]   sr;
    logic [4:0]    fill;
    logic [2:0]    bit_cnt;
    logic [7:0]    byte_sr;
    logic [7:0]    remaining;
    logic [SW-1:0] stall_cnt;

    logic [15:0] sr_n;
    logic [7:0]  new_byte;
    logic        bit_done;
    logic        stall_hit;
    logic        xfer;
    logic        sync_hit;

    logic       start_ev;
    logic       err_ev;
    logic [1:0] err_val;
    logic       done_ev;
    logic       load_ev;
    logic       clr_ev;

    assign sr_n      = {sr[14:0], bit_in};
    assign new_byte  = {byte_sr[6:0], bit_in ^ polarity};
    assign bit_done  = bit_valid && (bit_cnt == 3'd7);
    assign stall_hit = !bit_valid && (stall_cnt == SW'(TIMEOUT_CYCLES - 1));
    assign xfer      = byte_valid && byte_ready;
    // fill reaches 16 with this bit when it is already at 15 or more
    assign sync_hit  = bit_valid && (fill >= 5'd15) &&
                       ((sr_n == SYNC_WORD) || (sr_n == ~SYNC_WORD));
    assign busy      = (state == LEN) || (state == PAYLOAD) ||
                       (state == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        start_ev = 1'b0;
        err_ev   = 1'b0;
        err_val  = 2'd0;
        done_ev  = 1'b0;
        load_ev  = 1'b0;
        clr_ev   = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            clr_ev  = 1'b1;
        end else begin
            unique case (state)
                IDLE: state_n = HUNT;
                HUNT: begin
                    if (sync_hit) begin
                        state_n  = LEN;
                        start_ev = 1'b1;
                    end
                end
                LEN: begin
                    if (stall_hit) begin
                        err_ev  = 1'b1;
                        err_val = 2'd3;
                    end else if (bit_done) begin
                        if (new_byte == 8'd0) begin
                            err_ev  = 1'b1;
                            err_val = 2'd1;
                        end else begin
                            state_n = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (stall_hit) begin
                        err_ev  = 1'b1;
                        err_val = 2'd3;
                    end else if (bit_done) begin
                        if (byte_valid && !byte_ready) begin
                            err_ev  = 1'b1;
                            err_val = 2'd2;
                        end else begin
                            load_ev = 1'b1;
                            if (remaining == 8'd1) state_n = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        done_ev = 1'b1;
                        clr_ev  = 1'b1;
                        state_n = HUNT;
                    end
                end
                default: state_n = IDLE;
            endcase
            if (err_ev) begin
                state_n = HUNT;
                clr_ev  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr          <= '0;
            fill        <= '0;
            bit_cnt     <= '0;
            byte_sr     <= '0;
            remaining   <= '0;
            stall_cnt   <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            byte_last   <= 1'b0;
            polarity    <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            frame_start <= start_ev;
            frame_done  <= done_ev;
            frame_err   <= err_ev;
            if (err_ev) begin
                err_code <= err_val;
            end else if (start_ev) begin
                err_code <= 2'd0;
            end
            if (state == HUNT && bit_valid) begin
                sr   <= sr_n;
                fill <= (fill == 5'd16) ? fill : fill + 5'd1;
            end
            if (state == LEN || state == PAYLOAD) begin
                if (bit_valid) begin
                    bit_cnt   <= bit_cnt + 3'd1;
                    byte_sr   <= new_byte;
                    stall_cnt <= '0;
                end else begin
                    stall_cnt <= stall_cnt + SW'(1);
                end
            end
            if (state == LEN && bit_done) remaining <= new_byte;
            if (start_ev) begin
                polarity  <= (sr_n != SYNC_WORD);
                bit_cnt   <= '0;
                stall_cnt <= '0;
                sr        <= '0;
                fill      <= '0;
            end
            if (xfer) begin
                byte_valid <= 1'b0;
                byte_last  <= 1'b0;
            end
            // a completing byte may replace one being taken this cycle
            if (load_ev) begin
                byte_data  <= new_byte;
                byte_valid <= 1'b1;
                byte_last  <= (remaining == 8'd1);
                remaining  <= remaining - 8'd1;
            end
            if (clr_ev) begin
                byte_valid <= 1'b0;
                byte_last  <= 1'b0;
                sr         <= '0;
                fill       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bpsk_rx_frame_ctrl.sv
// Scoreboarded bench for bpsk_rx_frame_ctrl: framing, polarity,
// aborts, handshake back-pressure and control inputs.
module tb_bpsk_rx_frame_ctrl;

    localparam int TO = 4096;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       byte_last;
    logic       polarity;
    logic       busy;
    logic       frame_start;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;

    int vectors = 0;
    int miscompares = 0;
    int n_start = 0;
    int n_done = 0;
    int n_err = 0;
    logic exp_done = 1'b0;
    logic [8:0] exp_q[$];

    bpsk_rx_frame_ctrl #(
        .SYNC_WORD(16'hD391),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .bit_in(bit_in),
        .bit_valid(bit_valid),
        .byte_data(byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .byte_last(byte_last),
        .polarity(polarity),
        .busy(busy),
        .frame_start(frame_start),
        .frame_done(frame_done),
        .frame_err(frame_err),
        .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: scoreboard sampling on the falling edge, then advance.
    task automatic step();
        logic [8:0] e;
        @(negedge clk);
        if (frame_start === 1'b1) n_start++;
        if (frame_err === 1'b1) n_err++;
        if (frame_done === 1'b1) n_done++;
        if (exp_done || frame_done) begin
            vectors++;
            if (frame_done !== exp_done || (exp_done && busy !== 1'b0)) begin
                miscompares++;
                $display("FAIL done_timing: done=%b busy=%b want done=%b busy=0",
                         frame_done, busy, exp_done);
            end
        end
        exp_done = byte_valid && byte_ready && byte_last && !rst && enable;
        if (byte_valid && byte_ready && !rst) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_byte: got %h last=%b want none",
                         byte_data, byte_last);
            end else begin
                e = exp_q.pop_front();
                if ({byte_last, byte_data} !== e) begin
                    miscompares++;
                    $display("FAIL byte: got last=%b data=%h want last=%b data=%h",
                             byte_last, byte_data, e[8], e[7:0]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        step();
        bit_valid = 1'b0;
        step();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_word(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic wait_done(input int d0);
        int k;
        k = 0;
        while (n_done == d0 && k < 60) begin
            step();
            k++;
        end
        vectors++;
        if (n_done != d0 + 1) begin
            miscompares++;
            $display("FAIL wait_done: got %0d done pulses want 1", n_done - d0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        byte_ready = 1'b1;
        repeat (3) step();
        vectors++;
        if ({byte_data, byte_valid, byte_last} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_byte: got %h/%b/%b want 0", byte_data, byte_valid, byte_last);
        end
        vectors++;
        if ({polarity, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_pol_busy: got %b%b want 00", polarity, busy);
        end
        vectors++;
        if ({frame_start, frame_done, frame_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_pulses: got %b%b%b want 000", frame_start, frame_done, frame_err);
        end
        vectors++;
        if (err_code !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_err_code: got %0d want 0", err_code);
        end
        rst = 1'b0;
        enable = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_true_sync();
        int s0;
        int d0;
        int e0;
        s0 = n_start;
        d0 = n_done;
        e0 = n_err;
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'h3C});
        exp_q.push_back({1'b1, 8'hFF});
        // 15 bits of D391, last bit checked cycle by cycle
        for (int i = 15; i >= 1; i--) send_bit(logic'((16'hD391 >> i) & 1));
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_sync_busy: got %b want 0", busy);
        end
        bit_in = 1'b1;
        bit_valid = 1'b1;
        step();
        vectors++;
        if ({frame_start, busy, polarity} !== 3'b110) begin
            miscompares++;
            $display("FAIL sync_start: got start/busy/pol=%b%b%b want 110",
                     frame_start, busy, polarity);
        end
        bit_valid = 1'b0;
        step();
        vectors++;
        if (frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL start_width: got %b want 0", frame_start);
        end
        send_byte(8'h03);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'hFF);
        wait_done(d0);
        vectors++;
        if (n_start != s0 + 1 || n_err != e0 || exp_q.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL true_frame: starts=%0d errs=%0d left=%0d busy=%b want 1 0 0 0",
                     n_start - s0, n_err - e0, exp_q.size(), busy);
        end
    endtask

    task automatic test_inverted();
        int d0;
        d0 = n_done;
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'h3C});
        exp_q.push_back({1'b1, 8'hFF});
        send_word(16'h2C6E);
        vectors++;
        if (polarity !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL inv_polarity: got pol=%b busy=%b want 1 1", polarity, busy);
        end
        send_byte(8'hFC);
        send_byte(8'h5A);
        send_byte(8'hC3);
        send_byte(8'h00);
        wait_done(d0);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL inv_left: got %0d bytes left want 0", exp_q.size());
        end
    endtask

    task automatic test_zero_length();
        int e0;
        int d0;
        e0 = n_err;
        send_word(16'hD391);
        send_byte(8'h00);
        vectors++;
        if (n_err != e0 + 1 || err_code !== 2'd1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len: errs=%0d code=%0d busy=%b want 1 1 0",
                     n_err - e0, err_code, busy);
        end
        d0 = n_done;
        exp_q.push_back({1'b1, 8'h42});
        send_word(16'hD391);
        vectors++;
        if (err_code !== 2'd0) begin
            miscompares++;
            $display("FAIL err_code_clear: got %0d want 0", err_code);
        end
        send_byte(8'h01);
        send_byte(8'h42);
        wait_done(d0);
    endtask

    task automatic test_overflow();
        int e0;
        e0 = n_err;
        byte_ready = 1'b0;
        send_word(16'hD391);
        send_byte(8'h02);
        send_byte(8'h11);
        vectors++;
        if (byte_valid !== 1'b1 || byte_data !== 8'h11) begin
            miscompares++;
            $display("FAIL ovf_hold: got valid=%b data=%h want 1 11", byte_valid, byte_data);
        end
        send_byte(8'h22);
        vectors++;
        if (n_err != e0 + 1 || err_code !== 2'd2 || byte_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow: errs=%0d code=%0d valid=%b busy=%b want 1 2 0 0",
                     n_err - e0, err_code, byte_valid, busy);
        end
        byte_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int e0;
        int d0;
        e0 = n_err;
        d0 = n_done;
        byte_ready = 1'b0;
        exp_q.push_back({1'b0, 8'h5E});
        exp_q.push_back({1'b1, 8'h81});
        send_word(16'hD391);
        send_byte(8'h02);
        send_byte(8'h5E);
        for (int i = 7; i >= 1; i--) send_bit(logic'((8'h81 >> i) & 1));
        byte_ready = 1'b1;
        bit_in = 1'b1;
        bit_valid = 1'b1;
        step();
        vectors++;
        if (byte_valid !== 1'b1 || byte_data !== 8'h81 || byte_last !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_replace: got valid=%b data=%h last=%b want 1 81 1",
                     byte_valid, byte_data, byte_last);
        end
        bit_valid = 1'b0;
        wait_done(d0);
        vectors++;
        if (n_err != e0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_no_err: errs=%0d left=%0d want 0 0", n_err - e0, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int cnt;
        exp_q.push_back({1'b0, 8'h77});
        send_word(16'hD391);
        send_byte(8'h02);
        send_byte(8'h77);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        bit_in = 1'b1;
        bit_valid = 1'b1;
        step();
        bit_valid = 1'b0;
        cnt = 0;
        while (frame_err !== 1'b1 && cnt < TO + 20) begin
            step();
            cnt++;
        end
        vectors++;
        if (cnt != TO) begin
            miscompares++;
            $display("FAIL timeout_latency: got %0d cycles want %0d", cnt, TO);
        end
        vectors++;
        if (err_code !== 2'd3 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_code: got code=%0d busy=%b want 3 0", err_code, busy);
        end
        step();
        vectors++;
        if (frame_err !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL timeout_pulse: got err=%b left=%0d want 0 0", frame_err, exp_q.size());
        end
    endtask

    task automatic test_enable_drop();
        int e0;
        e0 = n_err;
        exp_q.push_back({1'b0, 8'h10});
        send_word(16'hD391);
        send_byte(8'h03);
        send_byte(8'h10);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        enable = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0 || byte_valid !== 1'b0 || err_code !== 2'd0) begin
            miscompares++;
            $display("FAIL enable_drop: got busy=%b valid=%b code=%0d want 0 0 0",
                     busy, byte_valid, err_code);
        end
        step();
        vectors++;
        if (n_err != e0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL enable_no_err: errs=%0d left=%0d want 0 0", n_err - e0, exp_q.size());
        end
        enable = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_reset_mid_frame();
        byte_ready = 1'b0;
        send_word(16'h2C6E);
        send_byte(8'hFD);
        send_byte(8'h66);
        vectors++;
        if (byte_valid !== 1'b1 || byte_data !== 8'h99 || polarity !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_rst: got valid=%b data=%h pol=%b busy=%b want 1 99 1 1",
                     byte_valid, byte_data, polarity, busy);
        end
        rst = 1'b1;
        step();
        vectors++;
        if ({byte_data, byte_valid, byte_last, polarity, busy} !== 12'd0 ||
            {frame_start, frame_done, frame_err, err_code} !== 5'd0) begin
            miscompares++;
            $display("FAIL mid_rst: got data=%h v=%b l=%b p=%b b=%b code=%0d want all 0",
                     byte_data, byte_valid, byte_last, polarity, busy, err_code);
        end
        rst = 1'b0;
        byte_ready = 1'b1;
        repeat (2) step();
    endtask

    initial begin
        test_reset();
        test_true_sync();
        test_inverted();
        test_zero_length();
        test_overflow();
        test_back_to_back();
        test_timeout();
        test_enable_drop();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bpsk_rx_frame_ctrl.md
# bpsk_rx_frame_ctrl

Receive-side frame controller that sits directly behind `bpsk_demodulator_top`. It consumes the demodulated bit stream, hunts for a 16-bit sync word in both polarities, and resolves the BPSK 180° phase ambiguity from which polarity matched. It then reads a length byte and delivers payload bytes to the host/UART side over a valid/ready handshake. It also polices frame integrity: zero length, output overflow, and bit-stream stall timeout.

## Interface
Parameters:
- `SYNC_WORD`, 16'hD391: sync pattern, MSB received first.
- `TIMEOUT_CYCLES`, 4096: maximum number of clk cycles between `bit_valid` strobes inside a frame.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  receiver enable, level sensitive.
- `bit_in`  in  1  demodulated bit; sampled only when `bit_valid`=1.
- `bit_valid`  in  1  one-cycle strobe per recovered symbol.
- `byte_data`  out  8  payload byte, polarity-corrected.
- `byte_valid`  out  1  `byte_data` is valid.
- `byte_ready`  in  1  consumer accepts the byte; transfer occurs when `byte_valid` & `byte_ready`.
- `byte_last`  out  1  qualifies the final payload byte of the frame.
- `polarity`  out  1  0 = sync matched true, 1 = sync matched inverted.
- `busy`  out  1  high in states LEN, PAYLOAD and DRAIN.
- `frame_start`  out  1  one-cycle pulse on sync detect.
- `frame_done`  out  1  one-cycle pulse when the last byte is accepted.
- `frame_err`  out  1  one-cycle pulse on abort.
- `err_code`  out  2  0 none, 1 zero length, 2 overflow, 3 timeout. Holds its value until the next `frame_start`.

## Operation
- Reset value: state=IDLE. All outputs are 0, including the sync shift register, bit counter, stall counter and `err_code`.
- **IDLE**
  - If `enable`=1, go to HUNT on the next cycle.
  - Bits are ignored.
- **HUNT**
  - On `bit_valid`: `sr <= {sr[14:0], bit_in}`; the fill counter saturates at 16.
  - A match requires fill=16 on the updated value.
  - Updated `sr` == `SYNC_WORD`: set `polarity`=0 and go to LEN.
  - Updated `sr` == ~`SYNC_WORD`: set `polarity`=1 and go to LEN.
  - On entry to LEN: `frame_start` pulses, `err_code` clears, and the bit counter and stall counter clear.
- **LEN**
  - Shift in 8 bits MSB first; each bit is XORed with `polarity`.
  - On the 8th bit with len==0: pulse `frame_err`, set `err_code`=1, go to HUNT.
  - On the 8th bit otherwise: set `remaining`=len, go to PAYLOAD.
- **PAYLOAD**
  - Assemble bytes in the same way as LEN.
  - On the 8th bit: load `byte_data`, set `byte_valid`=1, set `byte_last`=(`remaining`==1), decrement `remaining`.
  - If `byte_last` is being set, go to DRAIN.
- **DRAIN**
  - Bits are ignored.
  - On transfer: pulse `frame_done`, then go to HUNT if `enable`=1, else IDLE.
- **Overflow**
  - Condition: a byte completes while `byte_valid`=1 and `byte_ready`=0.
  - Response: pulse `frame_err`, set `err_code`=2, go to HUNT.
- **Timeout**
  - In LEN or PAYLOAD, the stall counter increments on every cycle without `bit_valid` and clears on `bit_valid`.
  - When it reaches `TIMEOUT_CYCLES`: pulse `frame_err`, set `err_code`=3, go to HUNT.
- Every abort (error, or `enable` dropping) clears `byte_valid`, `byte_last`, the sync shift register and the fill counter.
- `enable`=0 in any state: go to IDLE on the next cycle, with no error pulse. `err_code` is retained.

## Timing
- The sync match bit's `bit_valid` at cycle t gives `frame_start`=1 and state LEN at t+1.
- The 8th bit of a byte at cycle t gives `byte_valid`=1 at t+1.
- After the transfer at cycle t, `byte_valid` is 0 at t+1.
- Byte completion in the same cycle as a transfer of the previous byte is not an overflow. The new byte replaces the old one, and `byte_valid` stays 1.
- The last byte's transfer at t gives `frame_done`=1 at t+1. The state is HUNT at t+1, with the shift register clear.
- `frame_err` occurs at t+1 after the triggering bit or stall cycle.
- Pulse outputs are high for exactly one cycle.
- `rst` has priority over every other input, in every state.
- Reset mid-frame yields the reset values on the next cycle.
- `remaining` is 8 bits, so the maximum payload is 255 bytes.

## Test plan
- **True sync, 3 bytes:** sync D391, length 03, payload A5 3C FF, `byte_ready`=1 → `frame_start` pulse, `polarity`=0, bytes A5/3C/FF with `byte_last` on FF, then `frame_done`.
- **Inverted stream:** stream 2C6E, FC, 5A C3 00 (all bits inverted) → `polarity`=1, bytes A5 3C FF.
- **Zero length:** sync then 00 → `frame_err`, `err_code`=1, back in HUNT. A following valid frame is then received.
- **Overflow:** length 02, `byte_ready` held 0 → `frame_err`, `err_code`=2 at completion of the second byte, and `byte_valid` drops.
- **Timeout:** `bit_valid` stops for `TIMEOUT_CYCLES` mid-payload → `frame_err`, `err_code`=3 exactly `TIMEOUT_CYCLES` cycles after the last strobe.
- **Control:** deassert `enable` mid-payload → IDLE, `busy`=0, no `frame_err`. Assert `rst` mid-frame → all outputs 0 on the next cycle.
